// File: rtl/nios_system_bmp_pixin.sv
// Avalon-MM slave that buffers 24-bit fabric pixels in a small FIFO for the Nios II.
// Software pops pixels via DATA, and polls or takes an irq via STATUS/IRQ_MASK/CONTROL.
module nios_system_bmp_pixin #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  read_n,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic                  irq,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready
);

  localparam logic [1:0] A_DATA = 2'd0;
  localparam logic [1:0] A_STAT = 2'd1;
  localparam logic [1:0] A_MASK = 2'd2;
  localparam logic [1:0] A_CTRL = 2'd3;
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0]  head, tail;
  logic [PTR_WIDTH:0]    count, count_next;
  logic                  ovf, unf, ovf_next, unf_next;
  logic [1:0]            mask, mask_next;

  logic rd, wr, empty, full, push, pop, flush, do_push, do_pop;
  logic ovf_set, unf_set, ovf_clr, unf_clr;

  logic [PTR_WIDTH:0] cnt_v;
  logic               empty_v, full_v, ovf_v, unf_v;
  logic [1:0]         mask_v;
  logic [31:0]        head_word;
  logic               unused_wdata;

  assign unused_wdata = ^{writedata[31:12], writedata[9:2]};

  always_comb begin
    rd      = chipselect & ~read_n;
    wr      = chipselect & ~write_n;
    empty   = (count == '0);
    full    = (count == DEPTH_C);
    in_ready = ~reset_n | ~full;
    push    = in_valid & in_ready;
    pop     = rd & (address == A_DATA) & ~empty;
    flush   = wr & (address == A_CTRL) & writedata[0];
    do_push = push & ~flush;
    do_pop  = pop & ~flush;
    // A pop while full frees a slot, so that stalled word is not counted as lost.
    ovf_set = in_valid & full & ~pop & ~flush;
    unf_set = rd & (address == A_DATA) & empty;
    ovf_clr = wr & (address == A_STAT) & writedata[10];
    unf_clr = wr & (address == A_STAT) & writedata[11];
    ovf_next = ovf_set | (ovf & ~ovf_clr);
    unf_next = unf_set | (unf & ~unf_clr);
    mask_next = (wr & (address == A_MASK)) ? writedata[1:0] : mask;
    count_next = count;
    if (flush)                 count_next = '0;
    else if (do_push & ~do_pop) count_next = count + 1'b1;
    else if (do_pop & ~do_push) count_next = count - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      mask  <= 2'b00;
      irq   <= 1'b0;
    end else begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (do_pop)  head <= head + 1'b1;
        if (do_push) tail <= tail + 1'b1;
      end
      count <= count_next;
      ovf   <= ovf_next;
      unf   <= unf_next;
      mask  <= mask_next;
      irq   <= (mask_next[0] & (count_next != '0)) | (mask_next[1] & ovf_next);
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n & do_push) mem[tail] <= in_data;
  end

  // Register reads see the reset state while reset_n is low, even before the first edge.
  always_comb begin
    cnt_v   = reset_n ? count : '0;
    empty_v = ~reset_n | empty;
    full_v  = reset_n & full;
    ovf_v   = reset_n & ovf;
    unf_v   = reset_n & unf;
    mask_v  = reset_n ? mask : 2'b00;
    head_word = '0;
    head_word[DATA_WIDTH-1:0] = mem[head];
    readdata = '0;
    case (address)
      A_DATA: if (!empty_v) readdata = head_word;
      A_STAT: begin
        readdata[PTR_WIDTH:0] = cnt_v;
        readdata[8]  = empty_v;
        readdata[9]  = full_v;
        readdata[10] = ovf_v;
        readdata[11] = unf_v;
      end
      A_MASK: readdata[1:0] = mask_v;
      default: readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_nios_system_bmp_pixin.sv
// Bench for the pixel-in FIFO slave: directed literal checks plus a randomized run
// compared every cycle against a queue-based model.
module tb_nios_system_bmp_pixin;
  localparam int DW = 24;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [1:0]    address = 2'd0;
  logic          chipselect = 1'b0;
  logic          read_n = 1'b1;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic          irq;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;

  nios_system_bmp_pixin #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .PTR_WIDTH(3)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read_n(read_n), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q[$];
  bit            m_ovf, m_unf, m_irq;
  bit [1:0]      m_mask;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input logic [1:0] a);
    logic [31:0] r;
    r = '0;
    if (!reset_n) return (a == 2'd1) ? 32'h100 : 32'h0;
    case (a)
      2'd0: if (q.size() != 0) r[DW-1:0] = q[0];
      2'd1: begin
        r[3:0] = 4'(q.size());
        r[8]   = (q.size() == 0);
        r[9]   = (q.size() == DEPTH);
        r[10]  = m_ovf;
        r[11]  = m_unf;
      end
      2'd2: r[1:0] = m_mask;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Model: FIFO as a queue, flags/mask as bits, updated from the inputs seen at each edge.
  always @(posedge clk) begin : model
    bit rdv, wrv, fl, popping, fullv, emptyv, ovfset, unfset;
    if (!reset_n) begin
      q.delete();
      m_ovf = 0; m_unf = 0; m_mask = 0; m_irq = 0;
    end else begin
      rdv = chipselect && !read_n;
      wrv = chipselect && !write_n;
      fl = wrv && address == 2'd3 && writedata[0];
      fullv = (q.size() == DEPTH);
      emptyv = (q.size() == 0);
      popping = rdv && address == 2'd0 && !emptyv;
      ovfset = in_valid && fullv && !popping && !fl;
      unfset = rdv && address == 2'd0 && emptyv;
      if (fl) q.delete();
      else begin
        if (popping) void'(q.pop_front());
        if (in_valid && !fullv) q.push_back(in_data);
      end
      m_ovf = ovfset || (m_ovf && !(wrv && address == 2'd1 && writedata[10]));
      m_unf = unfset || (m_unf && !(wrv && address == 2'd1 && writedata[11]));
      if (wrv && address == 2'd2) m_mask = writedata[1:0];
      m_irq = (m_mask[0] && q.size() != 0) || (m_mask[1] && m_ovf);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cmp_readdata", readdata, exp_rdata(address));
      check("cmp_in_ready", {31'b0, in_ready}, {31'b0, (!reset_n || q.size() < DEPTH)});
      check("cmp_irq", {31'b0, irq}, {31'b0, m_irq});
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic rd_reg(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1; read_n = 0;
    @(negedge clk); d = readdata;
    cyc();
    chipselect = 0; read_n = 1;
  endtask

  task automatic wr_reg(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1; write_n = 0;
    cyc();
    chipselect = 0; write_n = 1; writedata = '0;
  endtask

  task automatic expect_rd(input string n, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    rd_reg(a, d);
    check(n, d, e);
  endtask

  task automatic push(input logic [DW-1:0] w);
    in_data = w; in_valid = 1; cyc(); in_valid = 0;
  endtask

  task automatic neg_chk(input string n, input logic [31:0] act_sel, input logic [31:0] e);
    check(n, act_sel, e);
  endtask

  initial begin
    cyc();
    chk_en = 1;
    // Reset state is visible combinationally
    address = 2'd1;
    @(negedge clk);
    check("reset_status", readdata, 32'h100);
    check("reset_in_ready", {31'b0, in_ready}, 32'h1);
    cyc();
    reset_n = 1;
    expect_rd("status_after_reset", 2'd1, 32'h100);
    @(negedge clk);
    check("irq_after_reset", {31'b0, irq}, 32'h0);
    cyc();
    expect_rd("data_empty", 2'd0, 32'h0);
    expect_rd("status_unf", 2'd1, 32'h900);
    wr_reg(2'd1, 32'h800);

    // Two words in, three reads out
    push(24'h123456);
    push(24'hABCDEF);
    expect_rd("status_cnt2", 2'd1, 32'h002);
    expect_rd("data_w0", 2'd0, 32'h00123456);
    expect_rd("status_cnt1", 2'd1, 32'h001);
    expect_rd("data_w1", 2'd0, 32'h00ABCDEF);
    expect_rd("status_cnt0", 2'd1, 32'h100);
    expect_rd("data_w2_empty", 2'd0, 32'h0);
    expect_rd("status_unf2", 2'd1, 32'h900);
    wr_reg(2'd1, 32'h800);

    // Nine pushes with in_valid held: the ninth overflows
    for (int i = 1; i <= 9; i++) begin
      in_data = DW'(i); in_valid = 1;
      @(negedge clk);
      check("fill_in_ready", {31'b0, in_ready}, (i <= 8) ? 32'h1 : 32'h0);
      cyc();
    end
    in_valid = 0;
    expect_rd("status_full_ovf", 2'd1, 32'h608);
    wr_reg(2'd1, 32'h400);
    expect_rd("status_ovf_clr", 2'd1, 32'h208);

    // Pop while full with in_valid: no push, no OVF
    in_data = 24'h0000AA; in_valid = 1;
    address = 2'd0; chipselect = 1; read_n = 0;
    @(negedge clk);
    check("popfull_data", readdata, 32'h1);
    check("popfull_in_ready", {31'b0, in_ready}, 32'h0);
    cyc();
    in_valid = 0; chipselect = 0; read_n = 1;
    @(negedge clk);
    check("popfull_ready_next", {31'b0, in_ready}, 32'h1);
    cyc();
    expect_rd("status_cnt7", 2'd1, 32'h007);
    for (int i = 2; i <= 8; i++) expect_rd("drain_data", 2'd0, 32'(i));
    expect_rd("status_drained", 2'd1, 32'h100);

    // Not-empty interrupt, then overflow interrupt
    wr_reg(2'd2, 32'h1);
    expect_rd("mask_rb", 2'd2, 32'h1);
    in_data = 24'h5A5A5A; in_valid = 1;
    @(negedge clk);
    check("irq_pre_push", {31'b0, irq}, 32'h0);
    cyc();
    in_valid = 0;
    @(negedge clk);
    check("irq_post_push", {31'b0, irq}, 32'h1);
    cyc();
    address = 2'd0; chipselect = 1; read_n = 0;
    @(negedge clk);
    check("irq_pre_pop", {31'b0, irq}, 32'h1);
    cyc();
    chipselect = 0; read_n = 1;
    @(negedge clk);
    check("irq_post_pop", {31'b0, irq}, 32'h0);
    cyc();
    wr_reg(2'd2, 32'h2);
    in_valid = 1;
    for (int i = 0; i < 9; i++) begin in_data = DW'(i + 32); cyc(); end
    in_valid = 0;
    @(negedge clk);
    check("irq_ovf", {31'b0, irq}, 32'h1);
    cyc();
    wr_reg(2'd1, 32'h400);
    @(negedge clk);
    check("irq_ovf_clr", {31'b0, irq}, 32'h0);
    cyc();
    wr_reg(2'd3, 32'h1);
    wr_reg(2'd2, 32'h0);

    // Flush racing a push, then reset with words queued
    for (int i = 0; i < 5; i++) push(DW'(16 + i));
    expect_rd("status_cnt5", 2'd1, 32'h005);
    in_data = 24'h777777; in_valid = 1;
    wr_reg(2'd3, 32'h1);
    in_valid = 0;
    expect_rd("status_flushed", 2'd1, 32'h100);
    expect_rd("data_after_flush", 2'd0, 32'h0);
    wr_reg(2'd1, 32'h800);
    for (int i = 0; i < 3; i++) push(DW'(48 + i));
    reset_n = 0;
    cyc();
    reset_n = 1;
    expect_rd("status_after_rst3", 2'd1, 32'h100);

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      reset_n    = ($urandom_range(299) != 0);
      in_valid   = $urandom_range(1);
      in_data    = DW'($urandom);
      address    = 2'($urandom_range(3));
      chipselect = ($urandom_range(9) < 4);
      if ($urandom_range(9) < 7) begin read_n = 0; write_n = 1; end
      else begin read_n = 1; write_n = 0; end
      writedata = $urandom;
      if (address == 2'd3 && $urandom_range(3) != 0) writedata[0] = 1'b0;
      cyc();
    end
    reset_n = 1; chipselect = 0; read_n = 1; write_n = 1; in_valid = 0;
    repeat (3) cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
